// File: rtl/sram_mem_ctrl_pkg.sv
// Shared definitions for the SRAM memory-stage controller.
// Holds the FSM state encoding, external SRAM bus widths and the default
// byte address that maps to SRAM word 0.
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_mem_ctrl.sv
// Memory-stage responder: splits one 32-bit load/store into two 16-bit SRAM
// accesses (low half, then high half), each held for WAIT_CYCLES cycles.
// Ports: clk/rst; rd_en/wr_en/address/write_data request from the pipeline;
// read_data/ready back to it (ready=0 freezes the pipeline); sram_* pins to
// the board SRAM (the DQ tri-state buffer sits above, driven by sram_dq_oe).
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  // Counter is at least one bit wide so WAIT_CYCLES=1 still elaborates.
  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
  localparam int            WORD_W   = SRAM_AW - 1;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_wr_q, op_wr_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [SRAM_DW-1:0]   lo_q, lo_d;
  logic [31:0]          read_data_q, read_data_d;
  logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
  logic [SRAM_DW-1:0]   sram_dq_out_q, sram_dq_out_d;
  logic                 sram_dq_oe_q, sram_dq_oe_d;
  logic                 sram_we_n_q, sram_we_n_d;

  logic [WORD_W-1:0]    req_word;
  logic                 req;
  logic                 cnt_last;

  // Halfword-pair index: byte offset from BASE_ADDR (wrapping), dropping the
  // byte-in-word bits and anything above the SRAM's reach.
  assign req_word = WORD_W'((address - BASE_ADDR) >> 2);
  assign req      = rd_en | wr_en;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_wr_d       = op_wr_q;
    word_d        = word_q;
    wdata_d       = wdata_q;
    lo_d          = lo_q;
    read_data_d   = read_data_q;
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_dq_oe_d  = sram_dq_oe_q;
    sram_we_n_d   = sram_we_n_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          // Store wins when both enables are asserted.
          op_wr_d      = wr_en;
          word_d       = req_word;
          wdata_d      = write_data;
          cnt_d        = '0;
          state_d      = LOW;
          sram_addr_d  = {req_word, 1'b0};
          sram_we_n_d  = ~wr_en;
          sram_dq_oe_d = wr_en;
          if (wr_en) begin
            sram_dq_out_d = write_data[15:0];
          end
        end
      end

      LOW: begin
        if (cnt_last) begin
          cnt_d       = '0;
          state_d     = HIGH;
          sram_addr_d = {word_q, 1'b1};
          if (op_wr_q) begin
            sram_dq_out_d = wdata_q[31:16];
          end else begin
            lo_d = sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HIGH: begin
        if (cnt_last) begin
          cnt_d        = '0;
          state_d      = DONE;
          // Release the bus on the edge that leaves HIGH.
          sram_we_n_d  = 1'b1;
          sram_dq_oe_d = 1'b0;
          if (!op_wr_q) begin
            read_data_d = {sram_dq_in, lo_q};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_wr_q       <= 1'b0;
      word_q        <= '0;
      wdata_q       <= '0;
      lo_q          <= '0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_wr_q       <= op_wr_d;
      word_q        <= word_d;
      wdata_q       <= wdata_d;
      lo_q          <= lo_d;
      read_data_q   <= read_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
    end
  end

  // An idle cycle with a pending request already reports not-ready so the
  // pipeline freezes on the same cycle it issues the access.
  assign ready = (state_q == DONE) | ((state_q == IDLE) & ~req);

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

  assign sram_ce_n = 1'b0;
  assign sram_oe_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with a small behavioural SRAM.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 time units after it.
module tb_sram_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  int          checks;
  int          errors;
  logic [31:0] rd_model;

  logic [15:0] mem [0:255];

  sram_mem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_ub_n   (sram_ub_n),
    .sram_lb_n   (sram_lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: write at the clock edge while we_n is low.
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
  end
  assign sram_dq_in = mem[sram_addr[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access with WAIT_CYCLES=2: cycle 0 IDLE, 1-2 LOW, 3-4 HIGH, 5 DONE.
  // Checks run up to and including cycle index 'last'.
  task automatic access(input string tag, input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input int last);
    logic [16:0] w;
    w = 17'((a - 32'd1024) >> 2);
    @(posedge clk); #1;
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    for (int i = 0; i <= last; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      #1;
      if (i == 0) begin
        chk($sformatf("%s c%0d ready", tag, i), {31'd0, ready}, 32'd0);
      end else if (i <= 4) begin
        chk($sformatf("%s c%0d addr", tag, i), {14'd0, sram_addr}, {14'd0, w, (i > 2) ? 1'b1 : 1'b0});
        chk($sformatf("%s c%0d we_n", tag, i), {31'd0, sram_we_n}, {31'd0, ~wr});
        chk($sformatf("%s c%0d oe", tag, i), {31'd0, sram_dq_oe}, {31'd0, wr});
        if (wr) chk($sformatf("%s c%0d dq_out", tag, i), {16'd0, sram_dq_out},
                    {16'd0, (i > 2) ? d[31:16] : d[15:0]});
        chk($sformatf("%s c%0d ready", tag, i), {31'd0, ready}, 32'd0);
        chk($sformatf("%s c%0d rdata", tag, i), read_data, rd_model);
      end else begin
        if (!wr) rd_model = exp_rd;
        chk($sformatf("%s c%0d ready", tag, i), {31'd0, ready}, 32'd1);
        chk($sformatf("%s c%0d we_n", tag, i), {31'd0, sram_we_n}, 32'd1);
        chk($sformatf("%s c%0d oe", tag, i), {31'd0, sram_dq_oe}, 32'd0);
        chk($sformatf("%s c%0d rdata", tag, i), read_data, rd_model);
      end
    end
  endtask

  task automatic drop(input string tag);
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    #1;
    chk({tag, " drop ready"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rd_model   = 32'd0;
    rst        = 1'b1;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    chk("rst rdata", read_data, 32'd0);
    chk("rst addr", {14'd0, sram_addr}, 32'd0);
    chk("rst dq_out", {16'd0, sram_dq_out}, 32'd0);
    chk("rst oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst ready", {31'd0, ready}, 32'd1);
    chk("tied pins", {28'd0, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'd0);
    rst = 1'b0;

    // Store 0xDEADBEEF at 1032 -> halfwords 4 (BEEF) and 5 (DEAD).
    access("store", 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 32'd0, 5);
    chk("store mem4", {16'd0, mem[4]}, 32'h0000BEEF);
    chk("store mem5", {16'd0, mem[5]}, 32'h0000DEAD);
    drop("store");

    // Seed word 0 for the later back-to-back load.
    access("seed", 1'b1, 1'b0, 32'd1024, 32'h3C3CA5A5, 32'd0, 5);
    drop("seed");

    // Idle passthrough.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      chk($sformatf("idle c%0d ready", i), {31'd0, ready}, 32'd1);
      chk($sformatf("idle c%0d we_n", i), {31'd0, sram_we_n}, 32'd1);
      chk($sformatf("idle c%0d rdata", i), read_data, rd_model);
    end

    // Load back the store.
    access("load", 1'b0, 1'b1, 32'd1032, 32'd0, 32'hDEADBEEF, 5);
    drop("load");

    // Back-to-back: load at 1024 then store at 1028 right after DONE.
    access("b2b_ld", 1'b0, 1'b1, 32'd1024, 32'd0, 32'h3C3CA5A5, 5);
    access("b2b_st", 1'b1, 1'b0, 32'd1028, 32'h0BADF00D, 32'd0, 5);
    chk("b2b mem2", {16'd0, mem[2]}, 32'h0000F00D);
    chk("b2b mem3", {16'd0, mem[3]}, 32'h00000BAD);
    drop("b2b");

    // Both enables: a write happens, read_data untouched.
    access("both", 1'b1, 1'b1, 32'd1036, 32'h12345678, 32'd0, 5);
    chk("both mem6", {16'd0, mem[6]}, 32'h00005678);
    chk("both mem7", {16'd0, mem[7]}, 32'h00001234);
    chk("both rdata", read_data, 32'h3C3CA5A5);
    drop("both");

    // Reset during the HIGH phase of a write.
    access("rstmid", 1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, 32'd0, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    rd_model = 32'd0;
    #1;
    chk("rstmid we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rstmid oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rstmid rdata", read_data, 32'd0);
    chk("rstmid addr", {14'd0, sram_addr}, 32'd0);
    chk("rstmid ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #2;
    chk("rstmid idle ready", {31'd0, ready}, 32'd1);
    chk("rstmid idle we_n", {31'd0, sram_we_n}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
